fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 144 ++++++++++++++
 tb/tb_fetch_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch queue: pulls 64-bit instruction pairs from memory and
// presents the two oldest instructions to the decode slots.
module fetch_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic [1:0]  dec_pop,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        slot0_valid,
  output logic        slot1_valid,
  output logic [31:0] slot0_instr,
  output logic [31:0] slot1_instr,
  output logic [31:0] slot0_pc,
  output logic [31:0] slot1_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CW-1:0] count_q, count_d, pop_req, pop_n, push_n;
  logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic          skip_lo_q, skip_lo_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;
  logic          started_q, started_d;

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          rsp_live, push_lo, push_hi, space_ok;
  logic          wr0_en, wr1_en;
  logic [31:0]   wr0_instr, wr0_pc;
  logic          unused_flush_bits;

  assign unused_flush_bits = ^flush_pc[1:0];

  assign head1 = head_q + PW'(1);
  assign tail1 = tail_q + PW'(1);

  // Slot contents are zeroed when invalid so reset drives clean outputs.
  assign slot0_valid = (count_q != '0);
  assign slot1_valid = (count_q >= CW'(2));
  assign slot0_instr = slot0_valid ? instr_mem_q[head_q] : '0;
  assign slot0_pc    = slot0_valid ? pc_mem_q[head_q]    : '0;
  assign slot1_instr = slot1_valid ? instr_mem_q[head1]  : '0;
  assign slot1_pc    = slot1_valid ? pc_mem_q[head1]     : '0;

  assign space_ok  = (count_q <= CW'(DEPTH - 2));
  assign imem_req  = started_q && !outstanding_q && !discard_q && !flush && space_ok;
  assign imem_addr = fetch_pc_q;

  assign rsp_live = imem_rvalid && outstanding_q;
  assign push_hi  = rsp_live && !discard_q && !flush;
  assign push_lo  = push_hi && !skip_lo_q;
  assign push_n   = CW'(push_lo) + CW'(push_hi);

  assign pop_req = (dec_pop == 2'd0) ? CW'(0) : (dec_pop == 2'd1) ? CW'(1) : CW'(2);
  assign pop_n   = (count_q < pop_req) ? count_q : pop_req;

  assign wr0_en    = push_hi;
  assign wr1_en    = push_lo;
  assign wr0_instr = push_lo ? imem_rdata[31:0] : imem_rdata[63:32];
  assign wr0_pc    = push_lo ? req_pc_q : req_pc_q + 32'd4;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    skip_lo_d     = skip_lo_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    started_d     = 1'b1;

    if (imem_req) begin
      fetch_pc_d    = fetch_pc_q + 32'd8;
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end
    if (rsp_live) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end

    // A flush only needs to drop a response that is still in flight.
    if (flush) begin
      count_d    = '0;
      head_d     = tail_q;
      fetch_pc_d = {flush_pc[31:3], 3'b000};
      skip_lo_d  = flush_pc[2];
      discard_d  = outstanding_q && !imem_rvalid;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + push_n - pop_n;
      if (push_hi) skip_lo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      skip_lo_q     <= 1'b0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      skip_lo_q     <= skip_lo_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      started_q     <= started_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      instr_mem_q[tail_q] <= wr0_instr;
      pc_mem_q[tail_q]    <= wr0_pc;
    end
    if (wr1_en) begin
      instr_mem_q[tail1] <= imem_rdata[63:32];
      pc_mem_q[tail1]    <= req_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a bench-side memory model feeds
// responses and a scoreboard queue tracks the expected instruction stream.
module tb_fetch_buffer;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  logic [1:0]  dec_pop;
  logic        flush;
  logic [31:0] flush_pc;
  logic        slot0_valid, slot1_valid;
  logic [31:0] slot0_instr, slot1_instr, slot0_pc, slot1_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      expQ[$];
  int          nChecks = 0;
  int          nFail   = 0;
  bit          memPending = 0;
  bit          memHold    = 0;
  bit          staleNow   = 0;
  int          memWait    = 0;
  int          memLat     = 1;
  logic [31:0] memAddr    = '0;
  logic [31:0] expFetch   = RESET_PC;
  bit          expDiscard = 0;
  bit          expSkip    = 0;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_pop(dec_pop), .flush(flush), .flush_pc(flush_pc),
    .slot0_valid(slot0_valid), .slot1_valid(slot1_valid),
    .slot0_instr(slot0_instr), .slot1_instr(slot1_instr),
    .slot0_pc(slot0_pc), .slot1_pc(slot1_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE ^ {a[15:0], a[31:16]};
  endfunction

  function automatic entry_t mkEntry(input logic [31:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = memWord(pc);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkSlots();
    int n;
    n = expQ.size();
    check("slot0_valid", 32'(slot0_valid), 32'(n >= 1));
    check("slot1_valid", 32'(slot1_valid), 32'(n >= 2));
    if (n >= 1) begin
      check("slot0_pc", slot0_pc, expQ[0].pc);
      check("slot0_instr", slot0_instr, expQ[0].instr);
    end
    if (n >= 2) begin
      check("slot1_pc", slot1_pc, expQ[1].pc);
      check("slot1_instr", slot1_instr, expQ[1].instr);
    end
  endtask

  task automatic checkResetOutputs();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_slot0_valid", 32'(slot0_valid), 32'd0);
    check("rst_slot1_valid", 32'(slot1_valid), 32'd0);
    check("rst_slot0_instr", slot0_instr, 32'd0);
    check("rst_slot1_instr", slot1_instr, 32'd0);
    check("rst_slot0_pc", slot0_pc, 32'd0);
    check("rst_slot1_pc", slot1_pc, 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs, update the scoreboard and
  // memory model, then advance past the edge and schedule any response.
  task automatic cycle(input logic [1:0] pop, input logic fl, input logic [31:0] fpc);
    int  n;
    bit  rvLive;
    dec_pop  = pop;
    flush    = fl;
    flush_pc = fpc;
    #1;
    checkSlots();
    rvLive = imem_rvalid && !staleNow;
    if (imem_req) begin
      check("single_outstanding", 32'(memPending), 32'd0);
      check("imem_addr", imem_addr, expFetch);
    end
    if (fl) begin
      expQ.delete();
      expDiscard = memPending && !rvLive;
      expFetch   = {fpc[31:3], 3'b000};
      expSkip    = fpc[2];
    end else begin
      n = (pop == 2'd0) ? 0 : (pop == 2'd1) ? 1 : 2;
      if (n > expQ.size()) n = expQ.size();
      repeat (n) void'(expQ.pop_front());
      if (rvLive) begin
        if (expDiscard) expDiscard = 0;
        else begin
          if (!expSkip) expQ.push_back(mkEntry(memAddr));
          expQ.push_back(mkEntry(memAddr + 32'd4));
          expSkip = 0;
        end
      end
    end
    if (rvLive) memPending = 0;
    if (imem_req) begin
      memPending = 1;
      memAddr    = imem_addr;
      memWait    = memLat;
      expFetch   = expFetch + 32'd8;
    end
    staleNow = 0;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (memPending && !memHold) begin
      if (memWait > 1) memWait--;
      else begin
        imem_rvalid = 1'b1;
        imem_rdata  = {memWord(memAddr + 32'd4), memWord(memAddr)};
      end
    end
  endtask

  initial begin
    logic [31:0] rnd;
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_pop     = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    #2 rst_n = 1'b1;

    // Fill from reset with single-cycle memory and no consumption.
    repeat (16) cycle(2'd0, 1'b0, 32'd0);
    check("fill_stops_req", 32'(imem_req), 32'd0);
    check("fill_slot0_pc", slot0_pc, RESET_PC);
    check("fill_slot1_pc", slot1_pc, RESET_PC + 32'd4);

    // Queue of 0,4,8,C: single pop then double pop.
    cycle(2'd0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && expQ.size() < 4; i++) cycle(2'd0, 1'b0, 32'd0);
    memHold = 1;
    check("q4_slot0_pc", slot0_pc, 32'h0);
    check("q4_slot1_pc", slot1_pc, 32'h4);
    cycle(2'd1, 1'b0, 32'd0);
    check("pop1_slot0_pc", slot0_pc, 32'h4);
    check("pop1_slot1_pc", slot1_pc, 32'h8);
    cycle(2'd2, 1'b0, 32'd0);
    check("pop2_slot0_pc", slot0_pc, 32'hC);
    check("pop2_slot1_valid", 32'(slot1_valid), 32'd0);

    // Flush while the request to 0x10 is held: that response is dropped.
    cycle(2'd0, 1'b1, 32'h104);
    check("flush_out_slot0_valid", 32'(slot0_valid), 32'd0);
    memHold = 0;
    for (int i = 0; i < 20 && expQ.size() < 1; i++) cycle(2'd0, 1'b0, 32'd0);
    check("skip_slot0_pc", slot0_pc, 32'h104);
    check("skip_slot1_valid", 32'(slot1_valid), 32'd0);
    check("after_skip_addr", imem_addr, 32'h108);

    // Flush with nothing in flight, odd low bits ignored.
    for (int i = 0; i < 20 && memPending; i++) cycle(2'd0, 1'b0, 32'd0);
    cycle(2'd0, 1'b1, 32'h207);
    check("flush_idle_slot0_valid", 32'(slot0_valid), 32'd0);
    check("flush_idle_addr", imem_addr, 32'h200);
    for (int i = 0; i < 20 && expQ.size() < 1; i++) cycle(2'd0, 1'b0, 32'd0);
    check("flush_idle_slot0_pc", slot0_pc, 32'h204);

    // Fill to full, then stream with single pops across pointer wrap.
    repeat (14) cycle(2'd0, 1'b0, 32'd0);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_slot1_valid", 32'(slot1_valid), 32'd1);
    repeat (30) cycle(2'd1, 1'b0, 32'd0);

    // Random consumption, latency and occasional redirects.
    for (int i = 0; i < 200; i++) begin
      memLat = $urandom_range(1, 3);
      rnd    = $urandom;
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), rnd & 32'h0000_3FFF);
    end
    memLat = 1;

    // Asynchronous reset with a request in flight.
    memHold = 1;
    for (int i = 0; i < 20 && !memPending; i++) cycle(2'd0, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs();
    expQ.delete();
    memPending  = 0;
    memHold     = 0;
    expFetch    = RESET_PC;
    expDiscard  = 0;
    expSkip     = 0;
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(2'd0, 1'b0, 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    imem_rvalid = 1'b1;
    imem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    staleNow    = 1;
    cycle(2'd0, 1'b0, 32'd0);
    repeat (6) cycle(2'd0, 1'b0, 32'd0);
    check("post_rst_slot0_pc", slot0_pc, RESET_PC);
    check("post_rst_slot1_pc", slot1_pc, RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
